// File: rtl/wb_seq_pkg.sv
// Shared definitions for the Wishbone write/readback sequencer:
// state encoding, error-counter width and the data pattern D(p,a).
package wb_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR     = 3'd1,
        ST_WR_GAP = 3'd2,
        ST_RD     = 3'd3,
        ST_RD_GAP = 3'd4,
        ST_FIN    = 3'd5
    } seq_state_e;

    localparam int ERR_W = 16;
    localparam logic [ERR_W-1:0] ERR_MAX = 16'hFFFF;

    // Widest pattern supported; callers truncate to their data width.
    localparam int PAT_W = 64;

    function automatic logic [PAT_W-1:0] seq_pattern(
        input logic [PAT_W-1:0] seed,
        input logic [PAT_W-1:0] pass,
        input logic [PAT_W-1:0] addr,
        input int unsigned      addr_w
    );
        return seed + (pass << addr_w) + addr;
    endfunction

endpackage

// File: rtl/wb_seq_watchdog.sv
// ACK wait counter for the sequencer; expired is raised in the last
// allowed wait cycle so the master can abandon the bus on the next edge.
module wb_seq_watchdog #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_r;

    // Wait-cycle counter, restarted on each entry into a bus cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en && !expired) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = en && (cnt_r == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/wb_seq_master.sv
// Wishbone classic master running write-then-readback sweeps over a slave
// and counting mismatches. Optional ACK timeout: define WB_SEQ_TIMEOUT_EN.
module wb_seq_master
    import wb_seq_pkg::*;
#(
    parameter int                ADDR_W      = 3,
    parameter int                DATA_W      = 32,
    parameter int                REPEAT      = 8,
    parameter logic [DATA_W-1:0] SEED        = 32'h0000_0000,
    parameter int                TIMEOUT_CYC = 16
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              START,
    input  logic              ACK_I,
    input  logic [DATA_W-1:0] DAT_I,
    output logic              CYC_O,
    output logic              STB_O,
    output logic              WE_O,
    output logic [ADDR_W-1:0] ADR_O,
    output logic [DATA_W-1:0] DAT_O,
    output logic              BUSY,
    output logic              DONE,
    output logic [ERR_W-1:0]  ERR_CNT,
    output logic              TMO_O
);

    localparam int PASS_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(REPEAT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

    seq_state_e        state_r, state_s;
    logic [PASS_W-1:0] pass_r, pass_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [ERR_W-1:0]  err_r, err_s;
    logic              tmo_r, tmo_s;
    logic              done_r, done_s;
    logic              busy_r, busy_s;
    logic              cyc_r, cyc_s;
    logic              we_r, we_s;
    logic [ADDR_W-1:0] adr_r, adr_s;
    logic [DATA_W-1:0] dat_r, dat_s;
    logic [DATA_W-1:0] exp_dat_s;
    logic              expired_s;
    logic              wd_clr_s;
    logic              wd_en_s;

`ifdef WB_SEQ_TIMEOUT_EN
    wb_seq_watchdog #(
        .LIMIT   (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (CLK_I),
        .rst     (RST_I),
        .clr     (wd_clr_s),
        .en      (wd_en_s),
        .expired (expired_s)
    );
`else
    assign expired_s = 1'b0;
`endif

    assign wd_en_s   = (state_r == ST_WR) || (state_r == ST_RD);
    assign wd_clr_s  = cyc_s && (state_s != state_r);
    assign exp_dat_s = DATA_W'(seq_pattern(PAT_W'(SEED), PAT_W'(pass_r), PAT_W'(addr_r), ADDR_W));

    // Next-state, sequence counters and next values of the registered outputs.
    always_comb begin
        state_s = state_r;
        pass_s  = pass_r;
        addr_s  = addr_r;
        err_s   = err_r;
        tmo_s   = tmo_r;
        done_s  = done_r;
        case (state_r)
            ST_IDLE, ST_FIN: begin
                if (START) begin
                    state_s = ST_WR;
                    pass_s  = {PASS_W{1'b0}};
                    addr_s  = {ADDR_W{1'b0}};
                    err_s   = {ERR_W{1'b0}};
                    tmo_s   = 1'b0;
                    done_s  = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_WR: begin
                if (ACK_I) begin
                    state_s = ST_WR_GAP;
                end else if (expired_s) begin
                    state_s = ST_FIN;
                    tmo_s   = 1'b1;
                    done_s  = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            ST_WR_GAP: begin
                state_s = ST_RD;
            end
            ST_RD: begin
                if (ACK_I) begin
                    state_s = ST_RD_GAP;
                    if ((DAT_I != exp_dat_s) && (err_r != ERR_MAX)) begin
                        err_s = err_r + 16'd1;
                    end else begin
                        err_s = err_r;
                    end
                end else if (expired_s) begin
                    state_s = ST_FIN;
                    tmo_s   = 1'b1;
                    done_s  = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            ST_RD_GAP: begin
                if (addr_r != ADDR_LAST) begin
                    addr_s  = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    state_s = ST_WR;
                end else begin
                    addr_s = {ADDR_W{1'b0}};
                    if (pass_r != PASS_LAST) begin
                        pass_s  = pass_r + {{(PASS_W-1){1'b0}}, 1'b1};
                        state_s = ST_WR;
                    end else begin
                        state_s = ST_FIN;
                        done_s  = 1'b1;
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Bus outputs follow the state being entered so they are registered.
        cyc_s  = (state_s == ST_WR) || (state_s == ST_RD);
        we_s   = (state_s == ST_WR);
        busy_s = (state_s == ST_WR) || (state_s == ST_WR_GAP) ||
                 (state_s == ST_RD) || (state_s == ST_RD_GAP);
        if (cyc_s) begin
            adr_s = addr_s;
        end else begin
            adr_s = {ADDR_W{1'b0}};
        end
        if (we_s) begin
            dat_s = DATA_W'(seq_pattern(PAT_W'(SEED), PAT_W'(pass_s), PAT_W'(addr_s), ADDR_W));
        end else begin
            dat_s = {DATA_W{1'b0}};
        end
    end

    // State and output registers.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_r <= ST_IDLE;
            pass_r  <= {PASS_W{1'b0}};
            addr_r  <= {ADDR_W{1'b0}};
            err_r   <= {ERR_W{1'b0}};
            tmo_r   <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            cyc_r   <= 1'b0;
            we_r    <= 1'b0;
            adr_r   <= {ADDR_W{1'b0}};
            dat_r   <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_s;
            pass_r  <= pass_s;
            addr_r  <= addr_s;
            err_r   <= err_s;
            tmo_r   <= tmo_s;
            done_r  <= done_s;
            busy_r  <= busy_s;
            cyc_r   <= cyc_s;
            we_r    <= we_s;
            adr_r   <= adr_s;
            dat_r   <= dat_s;
        end
    end

    assign CYC_O   = cyc_r;
    assign STB_O   = cyc_r;
    assign WE_O    = we_r;
    assign ADR_O   = adr_r;
    assign DAT_O   = dat_r;
    assign BUSY    = busy_r;
    assign DONE    = done_r;
    assign ERR_CNT = err_r;
    assign TMO_O   = tmo_r;

endmodule

// File: tb/tb_wb_seq_master.sv
// Scoreboard bench for wb_seq_master: a behavioural 8x32 BRAM slave, an
// expected-bus-cycle queue and an expected-completion queue.
module tb_wb_seq_master;

    logic        CLK_I = 1'b0;
    logic        RST_I;
    logic        START;
    logic        ACK_I;
    logic [31:0] DAT_I;
    logic        CYC_O, STB_O, WE_O;
    logic [2:0]  ADR_O;
    logic [31:0] DAT_O;
    logic        BUSY, DONE, TMO_O;
    logic [15:0] ERR_CNT;

    typedef struct {
        logic        we;
        logic [2:0]  adr;
        logic [31:0] dat;
    } bus_t;

    typedef struct {
        int          lat;
        logic [15:0] err;
        logic        tmo;
        bit          empty;
    } done_t;

    bus_t  exp_q[$];
    done_t done_q[$];
    bus_t  e;
    done_t d;

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;
    int start_cnt = 0;
    logic done_prev = 1'b0;

    // slave controls
    int  waits = 0;
    bit  stuck = 1'b0;
    bit  noack = 1'b0;
    int  wcnt  = 0;
    logic [31:0] mem [8];

    always #5 CLK_I = ~CLK_I;

    wb_seq_master dut (
        .CLK_I   (CLK_I),
        .RST_I   (RST_I),
        .START   (START),
        .ACK_I   (ACK_I),
        .DAT_I   (DAT_I),
        .CYC_O   (CYC_O),
        .STB_O   (STB_O),
        .WE_O    (WE_O),
        .ADR_O   (ADR_O),
        .DAT_O   (DAT_O),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .ERR_CNT (ERR_CNT),
        .TMO_O   (TMO_O)
    );

    assign ACK_I = CYC_O && STB_O && !noack && (wcnt == waits);
    assign DAT_I = mem[stuck ? (ADR_O & 3'b101) : ADR_O];

    always @(posedge CLK_I) begin
        cyc_n <= cyc_n + 1;
        if (ACK_I && WE_O) mem[ADR_O] <= DAT_O;
        if (CYC_O && STB_O && !ACK_I) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Monitor: compare every strobed cycle against the queue head, pop on ACK;
    // compare completion status on each DONE rising edge.
    always @(negedge CLK_I) begin
        if (CYC_O === 1'b1 || STB_O === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_stb", {CYC_O, STB_O}, 2'b00);
            end else begin
                e = exp_q[0];
                chk("cyc_eq_stb", {CYC_O, STB_O}, 2'b11);
                chk("we", WE_O, e.we);
                chk("adr", ADR_O, e.adr);
                if (e.we) chk("wdat", DAT_O, e.dat);
                if (ACK_I) void'(exp_q.pop_front());
            end
        end
        if (DONE === 1'b1 && done_prev !== 1'b1) begin
            if (done_q.size() == 0) begin
                chk("unexpected_done", DONE, 1'b0);
            end else begin
                d = done_q.pop_front();
                chk("done_latency", cyc_n - start_cnt, d.lat);
                chk("err_cnt", ERR_CNT, d.err);
                chk("tmo", TMO_O, d.tmo);
                chk("busy_at_done", BUSY, 1'b0);
                chk("cyc_at_done", {CYC_O, STB_O, WE_O}, 3'b000);
                if (d.empty) chk("bus_cycles_left", exp_q.size(), 0);
            end
        end
        done_prev <= DONE;
    end

    function automatic logic [31:0] pat(input int p, input int a);
        return 32'h0000_0000 + 32'(p * 8) + 32'(a);
    endfunction

    task automatic push_sweep();
        bus_t b;
        for (int p = 0; p < 8; p++) begin
            for (int a = 0; a < 8; a++) begin
                b.we = 1'b1; b.adr = 3'(a); b.dat = pat(p, a);
                exp_q.push_back(b);
                b.we = 1'b0; b.dat = 32'h0;
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic push_done(input int lat, input logic [15:0] err, input logic tmo, input bit empty);
        done_t dd;
        dd.lat = lat; dd.err = err; dd.tmo = tmo; dd.empty = empty;
        done_q.push_back(dd);
    endtask

    task automatic pulse_start();
        @(negedge CLK_I) START = 1'b1;
        @(negedge CLK_I) START = 1'b0;
        start_cnt = cyc_n;
    endtask

    task automatic wait_done(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            if (DONE === 1'b1) break;
            @(negedge CLK_I);
        end
        if (DONE !== 1'b1) chk("done_timeout", DONE, 1'b1);
        @(negedge CLK_I);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_bus"}, {CYC_O, STB_O, WE_O}, 3'b000);
        chk({tag, "_adr"}, ADR_O, 3'd0);
        chk({tag, "_dat"}, DAT_O, 32'h0);
        chk({tag, "_status"}, {BUSY, DONE, TMO_O}, 3'b000);
        chk({tag, "_err"}, ERR_CNT, 16'h0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 32'hDEAD_0000;
        RST_I = 1'b1;
        START = 1'b0;

        // reset and idle
        @(negedge CLK_I);
        check_idle("reset");
        @(negedge CLK_I);
        RST_I = 1'b0;
        repeat (5) @(negedge CLK_I);
        check_idle("idle");

        // zero-wait slave: 128 bus cycles, DONE 256 cycles after START
        push_sweep();
        push_done(256, 16'd0, 1'b0, 1'b1);
        pulse_start();
        wait_done(300);

        // address bit 1 stuck at 0 on reads: 4 of 8 addresses wrong per pass
        stuck = 1'b1;
        push_sweep();
        push_done(256, 16'd32, 1'b0, 1'b1);
        pulse_start();
        wait_done(300);
        chk("done_held", DONE, 1'b1);
        stuck = 1'b0;

        // three wait states per bus cycle
        waits = 3;
        push_sweep();
        push_done(640, 16'd0, 1'b0, 1'b1);
        pulse_start();
        wait_done(700);
        waits = 0;

        // reset during the read of pass 3 address 0, then restart
        push_sweep();
        push_done(256, 16'd0, 1'b0, 1'b1);
        pulse_start();
        repeat (98) @(negedge CLK_I);
        chk("pass3_rd", {STB_O, WE_O, ADR_O}, {1'b1, 1'b0, 3'd0});
        RST_I = 1'b1;
        @(negedge CLK_I);
        RST_I = 1'b0;
        exp_q.delete();
        done_q.delete();
        check_idle("mid_reset");
        push_sweep();
        push_done(256, 16'd0, 1'b0, 1'b1);
        pulse_start();
        wait_done(300);

        // slave that never acknowledges
        noack = 1'b1;
        begin
            bus_t b;
            b.we = 1'b1; b.adr = 3'd0; b.dat = pat(0, 0);
            exp_q.push_back(b);
        end
`ifdef WB_SEQ_TIMEOUT_EN
        push_done(16, 16'd0, 1'b1, 1'b0);
        pulse_start();
        wait_done(60);
        chk("tmo_held", {TMO_O, DONE, STB_O}, 3'b110);
`else
        pulse_start();
        repeat (40) @(negedge CLK_I);
        chk("noack_stb_held", {CYC_O, STB_O, WE_O, BUSY}, 4'b1111);
        chk("noack_not_done", {DONE, TMO_O}, 2'b00);
        RST_I = 1'b1;
        @(negedge CLK_I);
        RST_I = 1'b0;
`endif
        exp_q.delete();
        noack = 1'b0;
        @(negedge CLK_I);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
